axis_dma_mem_responder: RTL and testbench
=========================================

Name: axis_dma_mem_responder

Overview:
Memory-side responder for the axis_dma memory interface. It services DMA byte-addressed write requests (mem_wr_*) and read requests (mem_rd_*) against a simple dual-port RAM with 1-cycle read latency. It returns read data on a backpressured valid/ready channel through a 2-entry buffer. A core-side port shares the RAM ports with strict priority over DMA, and per-direction packet counters are kept for status.

Parameters:
DATA_WIDTH, 64, data bus width in bits
ADDR_WIDTH, 16, byte address width
STRB_WIDTH, DATA_WIDTH/8, byte strobes per line
LINE_ADDR_WIDTH, ADDR_WIDTH-$clog2(STRB_WIDTH), RAM line address width
CNT_WIDTH, 32, packet counter width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
mem_wr_en  in  1  DMA write request
mem_wr_strb  in  STRB_WIDTH  byte enables
mem_wr_addr  in  ADDR_WIDTH  byte address
mem_wr_data  in  DATA_WIDTH  write data
mem_wr_last  in  1  last beat of packet
mem_wr_ready  out  1  DMA write accepted when en&&ready
mem_rd_en  in  1  DMA read request
mem_rd_addr  in  ADDR_WIDTH  byte address
mem_rd_last  in  1  last beat of packet
mem_rd_ready  out  1  DMA read accepted when en&&ready
mem_rd_data  out  DATA_WIDTH  read data, head of buffer
mem_rd_data_v  out  1  read data valid
mem_rd_data_ready  in  1  DMA consumes head when v&&ready
core_wr_en  in  1  core write (priority)
core_wr_strb  in  STRB_WIDTH  core byte enables
core_wr_addr  in  LINE_ADDR_WIDTH  core line address
core_wr_data  in  DATA_WIDTH  core write data
core_rd_en  in  1  core read (priority)
core_rd_addr  in  LINE_ADDR_WIDTH  core line address
core_rd_data  out  DATA_WIDTH  core read data
core_rd_valid  out  1  core_rd_en delayed one cycle
ram_wr_en  out  1  RAM write enable
ram_wr_strb  out  STRB_WIDTH  RAM byte enables
ram_wr_addr  out  LINE_ADDR_WIDTH  RAM write line address
ram_wr_data  out  DATA_WIDTH  RAM write data
ram_rd_en  out  1  RAM read enable
ram_rd_addr  out  LINE_ADDR_WIDTH  RAM read line address
ram_rd_data  in  DATA_WIDTH  RAM data, valid the cycle after ram_rd_en
wr_pkt_count  out  CNT_WIDTH  accepted DMA write beats with last
rd_pkt_count  out  CNT_WIDTH  accepted DMA read beats with last

Behaviour:
- Reset values: mem_rd_data_v=0, core_rd_valid=0, counters=0, buffer empty, credit=0, inflight flag=0. Reset mid-operation discards buffered and in-flight reads. Writes already issued to the RAM are not undone.
- Line address: byte address [ADDR_WIDTH-1:$clog2(STRB_WIDTH)]. Low bits are ignored and strobes pass through unchanged.
- Write path is combinational. mem_wr_ready = !core_wr_en.
  - core_wr_en=1: RAM write ports take the core values and the DMA beat is stalled.
  - Otherwise the RAM write ports take the DMA values, and ram_wr_en = mem_wr_en.
- Read issue:
  - mem_rd_ready = !core_rd_en && (credit < 2).
  - ram_rd_en = core_rd_en | (mem_rd_en & mem_rd_ready). The address mux follows the same priority.
- Credit counter (0..2):
  - +1 on DMA read accept, -1 on head pop (mem_rd_data_v && mem_rd_data_ready).
  - Both in the same cycle leave it unchanged.
  - Credit never exceeds 2 and never underflows.
- Read pipeline, for a DMA read accepted at edge t:
  - dma_inflight is set for cycle t+1.
  - ram_rd_data is pushed into the 2-entry FIFO at the end of t+1.
  - mem_rd_data_v is asserted from cycle t+2: issue-to-valid latency is 2 cycles.
- Sustained throughput is 1 beat/cycle when mem_rd_data_ready stays high.
- Push and pop in the same cycle are both legal. The FIFO cannot overflow because of the credit rule.
- mem_rd_data is driven from the FIFO head register. It holds stable while mem_rd_data_v && !mem_rd_data_ready.
- Core read: core_rd_valid <= core_rd_en; core_rd_data = ram_rd_data. It is never backpressured and never enters the FIFO.
- Counters:
  - wr_pkt_count +1 on mem_wr_en&&mem_wr_ready&&mem_wr_last.
  - rd_pkt_count +1 on mem_rd_en&&mem_rd_ready&&mem_rd_last.
  - Both wrap modulo 2^CNT_WIDTH.
- Same-line read and write in one cycle: the RAM is read-first and the responder does not forward. Callers must avoid the hazard.

Decomposition:
- Shared package: none required. The line-address derivation is a localparam.
- One sub-module is natural: axis_dma_rd_buf, a 2-entry FIFO with push/pop/head/valid and synchronous reset.
- Arbitration, credit counter and packet counters stay in the top module.

Test Plan:
- RAM preloaded mem[j]=j. DMA reads byte addrs 0x0,0x8,...,0x38 back-to-back with ready=1 → data 0..7 in order, first valid 2 cycles after the first accept, then 1 beat/cycle; rd_pkt_count=1 after the last beat.
- Same stream with mem_rd_data_ready low for 5 cycles mid-burst → mem_rd_ready drops once credit=2; no beat lost or duplicated; head data held stable.
- DMA write bursts at 0x100 (8 beats, strobe 0xFF, last on beat 8) while core_wr_en pulses on beats 3 and 6 → mem_wr_ready=0 on those cycles; RAM holds DMA data at lines 0x20..0x27; wr_pkt_count=1.
- core_rd_en asserted during a DMA read stream (line 0x40) → core_rd_valid one cycle later with data 0x40; DMA read stalled that cycle; DMA sequence intact.
- Assert rst with 2 reads buffered → next cycle mem_rd_data_v=0, mem_rd_ready=1, counters=0.
- Counter wrap: CNT_WIDTH=4 with 17 last-beat writes → wr_pkt_count=1.

Source files
------------

// File: rtl/axis_dma_mem_responder_pkg.sv
// Shared types and helpers for the axis_dma memory responder: read-port source
// selection and the saturating read-credit update.
package axis_dma_mem_responder_pkg;

  localparam int unsigned CREDIT_MAX = 2;

  typedef enum logic [1:0] {
    RD_SRC_NONE = 2'd0,
    RD_SRC_DMA  = 2'd1,
    RD_SRC_CORE = 2'd2
  } rd_src_e;

  typedef enum logic [1:0] {
    WR_SRC_DMA  = 2'd0,
    WR_SRC_CORE = 2'd1
  } wr_src_e;

  // Credit tracks DMA reads accepted but not yet popped from the buffer.
  function automatic logic [1:0] credit_next(input logic [1:0] credit,
                                             input logic       inc,
                                             input logic       dec);
    logic [1:0] nxt;
    case ({inc, dec})
      2'b10:   nxt = (credit < 2'(CREDIT_MAX)) ? credit + 2'd1 : credit;
      2'b01:   nxt = (credit != 2'd0) ? credit - 2'd1 : credit;
      default: nxt = credit;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/axis_dma_rd_buf.sv
// Two-entry read-data FIFO; the head entry drives the DMA read-data channel and
// holds until popped.
module axis_dma_rd_buf
  import axis_dma_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  valid
);

  logic [DATA_WIDTH-1:0] mem_r [0:1];
  logic                  wr_ptr_r;
  logic                  rd_ptr_r;
  logic [1:0]            count_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  always_comb begin
    pop_ok_s  = pop && (count_r != 2'd0);
    push_ok_s = push && ((count_r != 2'd2) || pop_ok_s);
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care while the entry is empty.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign valid = (count_r != 2'd0);

endmodule

// File: rtl/axis_dma_mem_responder.sv
// Memory-side responder for axis_dma: arbitrates core and DMA access to a
// dual-port RAM and returns DMA read data through a credit-limited buffer.
module axis_dma_mem_responder
  import axis_dma_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 16,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int LINE_ADDR_WIDTH = ADDR_WIDTH - $clog2(STRB_WIDTH),
  parameter int CNT_WIDTH       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_wr_en,
  input  logic [STRB_WIDTH-1:0]      mem_wr_strb,
  input  logic [ADDR_WIDTH-1:0]      mem_wr_addr,
  input  logic [DATA_WIDTH-1:0]      mem_wr_data,
  input  logic                       mem_wr_last,
  output logic                       mem_wr_ready,
  input  logic                       mem_rd_en,
  input  logic [ADDR_WIDTH-1:0]      mem_rd_addr,
  input  logic                       mem_rd_last,
  output logic                       mem_rd_ready,
  output logic [DATA_WIDTH-1:0]      mem_rd_data,
  output logic                       mem_rd_data_v,
  input  logic                       mem_rd_data_ready,
  input  logic                       core_wr_en,
  input  logic [STRB_WIDTH-1:0]      core_wr_strb,
  input  logic [LINE_ADDR_WIDTH-1:0] core_wr_addr,
  input  logic [DATA_WIDTH-1:0]      core_wr_data,
  input  logic                       core_rd_en,
  input  logic [LINE_ADDR_WIDTH-1:0] core_rd_addr,
  output logic [DATA_WIDTH-1:0]      core_rd_data,
  output logic                       core_rd_valid,
  output logic                       ram_wr_en,
  output logic [STRB_WIDTH-1:0]      ram_wr_strb,
  output logic [LINE_ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0]      ram_wr_data,
  output logic                       ram_rd_en,
  output logic [LINE_ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]      ram_rd_data,
  output logic [CNT_WIDTH-1:0]       wr_pkt_count,
  output logic [CNT_WIDTH-1:0]       rd_pkt_count
);

  localparam int OFFSET_BITS = $clog2(STRB_WIDTH);

  logic [LINE_ADDR_WIDTH-1:0] mem_wr_line_s;
  logic [LINE_ADDR_WIDTH-1:0] mem_rd_line_s;
  logic                       unused_addr_bits_s;
  wr_src_e                    wr_src_s;
  rd_src_e                    rd_src_s;
  logic                       dma_rd_accept_s;
  logic                       dma_wr_accept_s;
  logic                       buf_pop_s;
  logic                       buf_valid_s;
  logic [DATA_WIDTH-1:0]      buf_head_s;
  logic [1:0]                 credit_r;
  logic                       dma_inflight_r;
  logic                       core_rd_valid_r;
  logic [CNT_WIDTH-1:0]       wr_pkt_count_r;
  logic [CNT_WIDTH-1:0]       rd_pkt_count_r;

  // Byte offsets inside a line are ignored; strobes carry the byte selection.
  assign mem_wr_line_s      = mem_wr_addr[ADDR_WIDTH-1:OFFSET_BITS];
  assign mem_rd_line_s      = mem_rd_addr[ADDR_WIDTH-1:OFFSET_BITS];
  assign unused_addr_bits_s = ^{mem_wr_addr[OFFSET_BITS-1:0], mem_rd_addr[OFFSET_BITS-1:0]};

  // Write-port arbitration: core has strict priority and stalls the DMA beat.
  always_comb begin
    mem_wr_ready = !core_wr_en;
    wr_src_s     = WR_SRC_DMA;
    if (core_wr_en) begin
      wr_src_s = WR_SRC_CORE;
    end else begin
      wr_src_s = WR_SRC_DMA;
    end
    ram_wr_en   = 1'b0;
    ram_wr_strb = '0;
    ram_wr_addr = '0;
    ram_wr_data = '0;
    case (wr_src_s)
      WR_SRC_CORE: begin
        ram_wr_en   = 1'b1;
        ram_wr_strb = core_wr_strb;
        ram_wr_addr = core_wr_addr;
        ram_wr_data = core_wr_data;
      end
      WR_SRC_DMA: begin
        ram_wr_en   = mem_wr_en;
        ram_wr_strb = mem_wr_strb;
        ram_wr_addr = mem_wr_line_s;
        ram_wr_data = mem_wr_data;
      end
      default: begin
        ram_wr_en = 1'b0;
      end
    endcase
  end

  // Read-port arbitration: DMA reads also need a free buffer credit.
  always_comb begin
    mem_rd_ready    = !core_rd_en && (credit_r < 2'(CREDIT_MAX));
    dma_rd_accept_s = mem_rd_en && mem_rd_ready;
    if (core_rd_en) begin
      rd_src_s = RD_SRC_CORE;
    end else if (dma_rd_accept_s) begin
      rd_src_s = RD_SRC_DMA;
    end else begin
      rd_src_s = RD_SRC_NONE;
    end
    ram_rd_en   = 1'b0;
    ram_rd_addr = '0;
    case (rd_src_s)
      RD_SRC_CORE: begin
        ram_rd_en   = 1'b1;
        ram_rd_addr = core_rd_addr;
      end
      RD_SRC_DMA: begin
        ram_rd_en   = 1'b1;
        ram_rd_addr = mem_rd_line_s;
      end
      default: begin
        ram_rd_en   = 1'b0;
        ram_rd_addr = '0;
      end
    endcase
  end

  assign dma_wr_accept_s = mem_wr_en && mem_wr_ready;
  assign buf_pop_s       = buf_valid_s && mem_rd_data_ready;

  // Read pipeline state, credit and packet counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_r        <= 2'd0;
      dma_inflight_r  <= 1'b0;
      core_rd_valid_r <= 1'b0;
      wr_pkt_count_r  <= '0;
      rd_pkt_count_r  <= '0;
    end else begin
      credit_r        <= credit_next(credit_r, dma_rd_accept_s, buf_pop_s);
      dma_inflight_r  <= dma_rd_accept_s;
      core_rd_valid_r <= core_rd_en;
      if (dma_wr_accept_s && mem_wr_last) begin
        wr_pkt_count_r <= wr_pkt_count_r + CNT_WIDTH'(1);
      end
      if (dma_rd_accept_s && mem_rd_last) begin
        rd_pkt_count_r <= rd_pkt_count_r + CNT_WIDTH'(1);
      end
    end
  end

  axis_dma_rd_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (dma_inflight_r),
    .push_data (ram_rd_data),
    .pop       (buf_pop_s),
    .head      (buf_head_s),
    .valid     (buf_valid_s)
  );

  assign mem_rd_data   = buf_head_s;
  assign mem_rd_data_v = buf_valid_s;
  assign core_rd_data  = ram_rd_data;
  assign core_rd_valid = core_rd_valid_r;
  assign wr_pkt_count  = wr_pkt_count_r;
  assign rd_pkt_count  = rd_pkt_count_r;

endmodule

// File: tb/tb_axis_dma_mem_responder.sv
// Directed bench for axis_dma_mem_responder with a behavioural read-first RAM.
module tb_axis_dma_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_wr_en;
  logic [7:0]  mem_wr_strb;
  logic [15:0] mem_wr_addr;
  logic [63:0] mem_wr_data;
  logic        mem_wr_last;
  logic        mem_wr_ready;
  logic        mem_rd_en;
  logic [15:0] mem_rd_addr;
  logic        mem_rd_last;
  logic        mem_rd_ready;
  logic [63:0] mem_rd_data;
  logic        mem_rd_data_v;
  logic        mem_rd_data_ready;
  logic        core_wr_en;
  logic [7:0]  core_wr_strb;
  logic [12:0] core_wr_addr;
  logic [63:0] core_wr_data;
  logic        core_rd_en;
  logic [12:0] core_rd_addr;
  logic [63:0] core_rd_data;
  logic        core_rd_valid;
  logic        ram_wr_en;
  logic [7:0]  ram_wr_strb;
  logic [12:0] ram_wr_addr;
  logic [63:0] ram_wr_data;
  logic        ram_rd_en;
  logic [12:0] ram_rd_addr;
  logic [63:0] ram_rd_data;
  logic [3:0]  wr_pkt_count;
  logic [3:0]  rd_pkt_count;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int first_acc;
  int first_v;
  logic [63:0] got[$];
  logic [63:0] hold_val;
  logic        hold_seen = 1'b0;
  logic [63:0] ram_mem [0:8191];
  logic        preload_done = 1'b0;

  axis_dma_mem_responder #(
    .CNT_WIDTH (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_wr_en         (mem_wr_en),
    .mem_wr_strb       (mem_wr_strb),
    .mem_wr_addr       (mem_wr_addr),
    .mem_wr_data       (mem_wr_data),
    .mem_wr_last       (mem_wr_last),
    .mem_wr_ready      (mem_wr_ready),
    .mem_rd_en         (mem_rd_en),
    .mem_rd_addr       (mem_rd_addr),
    .mem_rd_last       (mem_rd_last),
    .mem_rd_ready      (mem_rd_ready),
    .mem_rd_data       (mem_rd_data),
    .mem_rd_data_v     (mem_rd_data_v),
    .mem_rd_data_ready (mem_rd_data_ready),
    .core_wr_en        (core_wr_en),
    .core_wr_strb      (core_wr_strb),
    .core_wr_addr      (core_wr_addr),
    .core_wr_data      (core_wr_data),
    .core_rd_en        (core_rd_en),
    .core_rd_addr      (core_rd_addr),
    .core_rd_data      (core_rd_data),
    .core_rd_valid     (core_rd_valid),
    .ram_wr_en         (ram_wr_en),
    .ram_wr_strb       (ram_wr_strb),
    .ram_wr_addr       (ram_wr_addr),
    .ram_wr_data       (ram_wr_data),
    .ram_rd_en         (ram_rd_en),
    .ram_rd_addr       (ram_rd_addr),
    .ram_rd_data       (ram_rd_data),
    .wr_pkt_count      (wr_pkt_count),
    .rd_pkt_count      (rd_pkt_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read-first RAM model, preloaded with mem[j] = j on the first edge.
  always @(posedge clk) begin
    if (!preload_done) begin
      for (int j = 0; j < 8192; j++) ram_mem[j] <= 64'(j);
      preload_done <= 1'b1;
    end else begin
      if (ram_rd_en) ram_rd_data <= ram_mem[ram_rd_addr];
      if (ram_wr_en)
        for (int b = 0; b < 8; b++)
          if (ram_wr_strb[b]) ram_mem[ram_wr_addr][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Collect popped beats, record first valid, and check head stability under stall.
  always @(negedge clk) begin
    if (!rst && mem_rd_data_v) begin
      if (first_v < 0) first_v = cyc;
      if (mem_rd_data_ready) begin
        got.push_back(mem_rd_data);
        hold_seen = 1'b0;
      end else begin
        if (hold_seen) check("head_hold", mem_rd_data, hold_val);
        hold_val  = mem_rd_data;
        hold_seen = 1'b1;
      end
    end else begin
      hold_seen = 1'b0;
    end
  end

  task automatic rd_stream(input int base, input int stall_at, input int core_at);
    int idx = 0;
    int c = 0;
    logic acc;
    logic core_prev = 1'b0;
    got.delete();
    first_acc = -1;
    first_v   = -1;
    while (idx < 8 && c < 100) begin
      if (core_prev) begin
        check("core_rd_valid", core_rd_valid, 1);
        check("core_rd_data", core_rd_data, 64'h40);
      end
      mem_rd_en         = 1'b1;
      mem_rd_addr       = 16'((base + idx) * 8);
      mem_rd_last       = (idx == 7);
      mem_rd_data_ready = !(stall_at >= 0 && c >= stall_at && c < stall_at + 5);
      core_rd_en        = (c == core_at);
      core_rd_addr      = 13'h40;
      #1;
      if (c == core_at) begin
        check("rd_ready_core", mem_rd_ready, 0);
        check("ram_rd_addr_core", ram_rd_addr, 64'h40);
      end
      if (stall_at >= 0 && c == stall_at + 4) begin
        check("rd_ready_full", mem_rd_ready, 0);
        check("rd_v_stalled", mem_rd_data_v, 1);
      end
      acc = mem_rd_ready;
      if (acc && first_acc < 0) first_acc = cyc;
      core_prev = (c == core_at);
      @(posedge clk); #1;
      if (acc) idx++;
      c++;
    end
    mem_rd_en = 1'b0; mem_rd_last = 1'b0; core_rd_en = 1'b0; mem_rd_data_ready = 1'b1;
    c = 0;
    while (got.size() < 8 && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    check("rd_beats", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8 && i < got.size(); i++) check("rd_data", got[i], 64'(base + i));
  endtask

  initial begin
    int idx;
    int c;
    logic acc;
    logic pulsed2;
    logic pulsed5;
    rst = 1'b1;
    mem_wr_en = 1'b0; mem_wr_strb = 8'h00; mem_wr_addr = 16'h0; mem_wr_data = 64'h0;
    mem_wr_last = 1'b0; mem_rd_en = 1'b0; mem_rd_addr = 16'h0; mem_rd_last = 1'b0;
    mem_rd_data_ready = 1'b1; core_wr_en = 1'b0; core_wr_strb = 8'h00; core_wr_addr = 13'h0;
    core_wr_data = 64'h0; core_rd_en = 1'b0; core_rd_addr = 13'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_v", mem_rd_data_v, 0);
    check("rst_core_v", core_rd_valid, 0);
    check("rst_rd_ready", mem_rd_ready, 1);
    check("rst_wr_cnt", wr_pkt_count, 0);
    check("rst_rd_cnt", rd_pkt_count, 0);

    // Plain read stream: lines 0..7, 2-cycle issue-to-valid.
    rd_stream(0, -1, -1);
    check("rd_latency", 64'(first_v - first_acc), 64'd2);
    check("rd_cnt1", rd_pkt_count, 1);

    // Same stream with a 5-cycle consumer stall.
    rd_stream(0, 2, -1);
    check("rd_cnt2", rd_pkt_count, 2);

    // DMA write burst at 0x100 with core writes stealing beats 3 and 6.
    idx = 0; c = 0; pulsed2 = 1'b0; pulsed5 = 1'b0;
    while (idx < 8 && c < 50) begin
      mem_wr_en    = 1'b1;
      mem_wr_addr  = 16'(16'h100 + idx * 8);
      mem_wr_data  = 64'hA5A5_0000_0000_0000 | 64'(idx);
      mem_wr_strb  = 8'hFF;
      mem_wr_last  = (idx == 7);
      core_wr_en   = (idx == 2 && !pulsed2) || (idx == 5 && !pulsed5);
      core_wr_addr = 13'(13'h60 + idx);
      core_wr_data = 64'hC0DE_0000_1234_0000 | 64'(idx);
      core_wr_strb = 8'h0F;
      if (idx == 2) pulsed2 = 1'b1;
      if (idx == 5) pulsed5 = 1'b1;
      #1;
      check("wr_ready", mem_wr_ready, !core_wr_en);
      check("ram_wr_addr", ram_wr_addr, core_wr_en ? 64'(13'h60 + idx) : 64'(13'h20 + idx));
      acc = mem_wr_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      c++;
    end
    mem_wr_en = 1'b0; mem_wr_last = 1'b0; core_wr_en = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) check("ram_dma_line", ram_mem[13'h20 + k], 64'hA5A5_0000_0000_0000 | 64'(k));
    check("ram_core_62", ram_mem[13'h62], 64'h0000_0000_1234_0002);
    check("ram_core_65", ram_mem[13'h65], 64'h0000_0000_1234_0005);
    check("wr_cnt1", wr_pkt_count, 1);

    // Core read of line 0x40 in the middle of a DMA stream over lines 0x10..0x17.
    rd_stream(16, -1, 3);
    check("rd_cnt3", rd_pkt_count, 3);

    // Reset with two beats buffered discards them.
    mem_rd_data_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_rd_en = 1'b1; mem_rd_addr = 16'(i * 8);
      @(posedge clk); #1;
    end
    mem_rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("buffered_v", mem_rd_data_v, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst2_v", mem_rd_data_v, 0);
    check("rst2_rd_ready", mem_rd_ready, 1);
    check("rst2_wr_cnt", wr_pkt_count, 0);
    check("rst2_rd_cnt", rd_pkt_count, 0);
    mem_rd_data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst2_v_later", mem_rd_data_v, 0);

    // 17 single-beat packets wrap a 4-bit counter to 1.
    for (int i = 0; i < 17; i++) begin
      mem_wr_en = 1'b1; mem_wr_last = 1'b1; mem_wr_strb = 8'hFF;
      mem_wr_addr = 16'h200; mem_wr_data = 64'(i);
      @(posedge clk); #1;
    end
    mem_wr_en = 1'b0; mem_wr_last = 1'b0;
    #1;
    check("wr_cnt_wrap", wr_pkt_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
